// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button conditioner.
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DB_PRESS = 3'd1,
    HELD     = 3'd2,
    REPEAT   = 3'd3,
    DB_REL   = 3'd4
  } btn_state_e;

  // Defaults assume a 50 MHz clk: 20 ms debounce, 500 ms hold, 100 ms repeat.
  localparam int unsigned DEF_DB_CYCLES   = 1_000_000;
  localparam int unsigned DEF_HOLD_CYCLES = 25_000_000;
  localparam int unsigned DEF_REP_CYCLES  = 5_000_000;

  // Smallest counter width that can hold max(db, hold, rep) - 1.
  function automatic int unsigned min_cnt_w(input int unsigned db,
                                            input int unsigned hold,
                                            input int unsigned rep);
    int unsigned m;
    int unsigned w;
    m = db;
    if (hold > m) m = hold;
    if (rep > m) m = rep;
    w = $clog2(m);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/btn_cond_ch.sv
// One button channel: 2-FF synchroniser, debounce/hold/repeat FSM, registered strobes.
//
// state    | meaning
// IDLE     | released and stable
// DB_PRESS | raw went active, counting stable-press cycles
// HELD     | press accepted, counting toward the first repeat
// REPEAT   | auto-repeating, one strobe every REP_CYCLES
// DB_REL   | raw went inactive, counting stable-release cycles
module btn_cond_ch
  import btn_pkg::*;
#(
  parameter bit          ACTIVE_LOW  = 1'b1,
  parameter int unsigned DB_CYCLES   = DEF_DB_CYCLES,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned REP_CYCLES  = DEF_REP_CYCLES,
  parameter int unsigned CNT_W       = 25
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_raw_i,
  output logic level_o,
  output logic clean_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o,
  output logic event_o
);

  localparam logic             RAW_IDLE  = ACTIVE_LOW;
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYCLES - 1);

  logic [1:0]       sync_q;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_q, repeat_d;
  logic             event_q;
  logic             act;

  assign act = sync_q[1] ^ RAW_IDLE;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q    <= {2{RAW_IDLE}};
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      event_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn_raw_i};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      event_q   <= press_d | repeat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (act) begin
          state_d = DB_PRESS;
          cnt_d   = '0;
        end
      end
      DB_PRESS: begin
        if (!act) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          press_d = 1'b1;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!act) begin
          state_d = DB_REL;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d  = REPEAT;
          cnt_d    = '0;
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REPEAT: begin
        if (!act) begin
          state_d = DB_REL;
          cnt_d   = '0;
        end else if (cnt_q == REP_LAST) begin
          cnt_d    = '0;
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DB_REL: begin
        // A bounce back to active restarts the hold timer rather than resuming it.
        if (act) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign level_o   = level_q;
  assign clean_o   = level_q ^ RAW_IDLE;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;
  assign event_o   = event_q;

endmodule

// File: rtl/btn_cond.sv
// Button conditioner top: N_BTN fully independent debounce/repeat channels.
module btn_cond
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN       = 2,
  parameter bit          ACTIVE_LOW  = 1'b1,
  parameter int unsigned DB_CYCLES   = DEF_DB_CYCLES,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned REP_CYCLES  = DEF_REP_CYCLES,
  parameter int unsigned CNT_W       = min_cnt_w(DB_CYCLES, HOLD_CYCLES, REP_CYCLES)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_clean,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic [N_BTN-1:0] btn_event
);

  for (genvar g = 0; g < int'(N_BTN); g++) begin : g_ch
    btn_cond_ch #(
      .ACTIVE_LOW  (ACTIVE_LOW),
      .DB_CYCLES   (DB_CYCLES),
      .HOLD_CYCLES (HOLD_CYCLES),
      .REP_CYCLES  (REP_CYCLES),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rstn      (rstn),
      .btn_raw_i (btn_raw[g]),
      .level_o   (btn_level[g]),
      .clean_o   (btn_clean[g]),
      .press_o   (btn_press[g]),
      .release_o (btn_release[g]),
      .repeat_o  (btn_repeat[g]),
      .event_o   (btn_event[g])
    );
  end

endmodule

// File: tb/tb_btn_cond.sv
// Directed bench for btn_cond: expected strobes are queued per edge and compared each cycle.
module tb_btn_cond;

  localparam int DB   = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] btn_raw;
  logic [1:0] btn_level, btn_clean, btn_press, btn_release, btn_repeat, btn_event;

  btn_cond #(
    .N_BTN       (2),
    .ACTIVE_LOW  (1'b1),
    .DB_CYCLES   (DB),
    .HOLD_CYCLES (HOLD),
    .REP_CYCLES  (REP),
    .CNT_W       (4)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_clean   (btn_clean),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_repeat  (btn_repeat),
    .btn_event   (btn_event)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_PRESS, EV_RELEASE, EV_REPEAT, EV_RESET} ev_kind_e;
  typedef struct {
    int       cyc;
    int       ch;
    ev_kind_e kind;
  } exp_ev_t;

  exp_ev_t    exp_q[$];
  int         cyc = 0;
  int         n_assert = 0;
  int         n_fail = 0;
  bit         chk_en = 1'b0;
  logic [1:0] exp_level = 2'b00;
  int         e0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(input int c, input int ch, input ev_kind_e k);
    exp_ev_t e;
    e.cyc  = c;
    e.ch   = ch;
    e.kind = k;
    exp_q.push_back(e);
  endfunction

  // Raw goes active at edge e_on and inactive at edge e_off; repeats fire while the
  // FSM (two edges behind raw) still sees the button held.
  function automatic void push_hold(input int ch, input int e_on, input int e_off);
    int p;
    p = e_on + DB + 2;
    push(p, ch, EV_PRESS);
    for (int t = p + HOLD; t <= e_off + 1; t += REP) push(t, ch, EV_REPEAT);
    push(e_off + DB + 2, ch, EV_RELEASE);
  endfunction

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expv);
    end
  endtask

  task automatic check_cycle();
    logic [1:0] e_press;
    logic [1:0] e_rel;
    logic [1:0] e_rep;
    e_press = 2'b00;
    e_rel   = 2'b00;
    e_rep   = 2'b00;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        case (exp_q[i].kind)
          EV_PRESS:   begin e_press[exp_q[i].ch] = 1'b1; exp_level[exp_q[i].ch] = 1'b1; end
          EV_RELEASE: begin e_rel[exp_q[i].ch] = 1'b1; exp_level[exp_q[i].ch] = 1'b0; end
          EV_REPEAT:  e_rep[exp_q[i].ch] = 1'b1;
          EV_RESET:   exp_level = 2'b00;
          default:    ;
        endcase
        exp_q.delete(i);
      end
    end
    check("press",   btn_press,   e_press);
    check("release", btn_release, e_rel);
    check("repeat",  btn_repeat,  e_rep);
    check("event",   btn_event,   e_press | e_rep);
    check("level",   btn_level,   exp_level);
    check("clean",   btn_clean,   ~exp_level);
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) check_cycle();
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rstn    = 1'b0;
    btn_raw = 2'b11;
    step(3);
    chk_en = 1'b1;
    step(1);
    rstn = 1'b1;
    step(4);

    // Clean press on ch0 held 30 cycles: press at +6, repeats from +16 every 3.
    e0 = cyc + 1;
    btn_raw[0] = 1'b0;
    push_hold(0, e0, e0 + 30);
    step(30);
    btn_raw[0] = 1'b1;
    step(12);

    // Bounce on ch0: 2 low / 2 high for 20 cycles, nothing accepted.
    for (int i = 0; i < 5; i++) begin
      btn_raw[0] = 1'b0;
      step(2);
      btn_raw[0] = 1'b1;
      step(2);
    end
    step(10);

    // Release glitch: 2 cycles inactive, 5 active, then released for good.
    e0 = cyc + 1;
    push(e0 + 6, 0, EV_PRESS);
    push(e0 + 21, 0, EV_RELEASE);
    btn_raw[0] = 1'b0;
    step(8);
    btn_raw[0] = 1'b1;
    step(2);
    btn_raw[0] = 1'b0;
    step(5);
    btn_raw[0] = 1'b1;
    step(12);

    // Simultaneous press on both channels.
    e0 = cyc + 1;
    push_hold(0, e0, e0 + 12);
    push_hold(1, e0, e0 + 12);
    btn_raw = 2'b00;
    step(12);
    btn_raw = 2'b11;
    step(12);

    // Reset while ch0 is repeating; button stays held through reset.
    e0 = cyc + 1;
    push(e0 + 6, 0, EV_PRESS);
    push(e0 + 16, 0, EV_REPEAT);
    push(e0 + 19, 0, EV_REPEAT);
    btn_raw[0] = 1'b0;
    step(20);
    rstn = 1'b0;
    push(e0 + 20, 0, EV_RESET);
    step(1);
    rstn = 1'b1;
    push_hold(0, e0 + 21, e0 + 33);
    step(12);
    btn_raw[0] = 1'b1;
    step(12);

    // Short 3-cycle pulse on ch1, then a normal press proves it fell back to IDLE.
    btn_raw[1] = 1'b0;
    step(3);
    btn_raw[1] = 1'b1;
    step(8);
    e0 = cyc + 1;
    push_hold(1, e0, e0 + 9);
    btn_raw[1] = 1'b0;
    step(9);
    btn_raw[1] = 1'b1;
    step(12);

    n_assert++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
